debug_controller: RTL and testbench

Parametrised debug controller between the UART word receiver/transmit FIFO and the MIPS pipeline. It loads programs into instruction memory and runs them in continuous, single-step or breakpoint mode. After every stop it dumps the register file, the flattened pipeline latches and the data memory into the transmit FIFO. Compared with the current debug unit it adds a configurable drain depth, a breakpoint mode, FIFO backpressure, load overflow protection and an optional skip of zero memory words.

---
 rtl/debug_controller.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_debug_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_controller.sv
// Debug controller between the UART word receiver / TX FIFO and the MIPS pipeline.
// Loads programs, runs them in continuous, step or breakpoint mode and dumps state after each stop.
module debug_controller #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned NREGS         = 32,
    parameter int unsigned LATCH_WORDS   = 11,
    parameter int unsigned MEM_ADDR_W    = 8,
    parameter int unsigned IMEM_WORDS    = 256,
    parameter int unsigned DRAIN_CYCLES  = 3,
    parameter bit          SKIP_ZERO_MEM = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_data_ready,
    input  logic [DATA_W-1:0]         i_data,
    input  logic                      i_fifo_full,
    input  logic                      i_program_end,
    input  logic [31:0]               i_pc,
    input  logic [LATCH_WORDS*32-1:0] i_latches,
    input  logic [DATA_W-1:0]         i_register_content,
    input  logic [DATA_W-1:0]         i_mem_data_content,
    output logic                      o_halt,
    output logic                      o_reset,
    output logic                      o_write_instruction_flag,
    output logic [31:0]               o_instruction_to_write,
    output logic [31:0]               o_address_to_write_inst,
    output logic [4:0]                o_reg_addr_to_read,
    output logic [31:0]               o_addr_to_read_mem_data,
    output logic [DATA_W-1:0]         o_data_to_fifo,
    output logic                      o_write_en_fifo
);
    localparam int unsigned MemWords = (2 ** MEM_ADDR_W) / 4;
    localparam logic [31:0] CmdLoad  = 32'h006c_6f6d;
    localparam logic [31:0] CmdCont  = 32'h0063_6f6d;
    localparam logic [31:0] CmdStep  = 32'h0073_746d;
    localparam logic [31:0] CmdBp    = 32'h0062_706d;
    localparam logic [31:0] CmdNext  = 32'h6e78_7374;
    localparam logic [31:0] CmdClear = 32'h636c_7374;
    localparam logic [31:0] WordEnd  = 32'h656e_6464;

    typedef enum logic [3:0] {
        StIdle, StLoad, StLoadWr, StRun, StStepWait, StStepRun,
        StBpAddr, StRunBp, StBpWait, StDumpAddr, StDumpPush
    } state_e;
    typedef enum logic [2:0] {PhReg, PhLatch, PhMemData, PhMemAddr, PhEnd} phase_e;
    typedef enum logic [1:0] {RetIdle, RetStep, RetBp} ret_e;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    ret_e              ret_q, ret_d;
    logic [15:0]       idx_q, idx_d;
    logic [31:0]       load_cnt_q, load_cnt_d, drain_cnt_q, drain_cnt_d, bp_addr_q, bp_addr_d;
    logic              prog_ready_q, prog_ready_d, bp_mask_q, bp_mask_d;
    logic              drain_active_q, drain_active_d;
    logic              halt_q, halt_d, rst_pulse_q, rst_pulse_d, wr_flag_q, wr_flag_d;
    logic [31:0]       instr_q, instr_d, inst_addr_q, inst_addr_d, mem_addr_q, mem_addr_d;
    logic [4:0]        reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] fifo_data_q, fifo_data_d, word_sel;
    logic              fifo_we_q, fifo_we_d;
    logic [31:0]       rx_word;
    logic              drain_fire, skip_word;

    assign rx_word = 32'(i_data);
    assign drain_fire = drain_active_q ? (drain_cnt_q == DRAIN_CYCLES - 1)
                                       : (i_program_end && (DRAIN_CYCLES == 0));
    assign skip_word = SKIP_ZERO_MEM && (phase_q == PhMemData) &&
                       ((i_mem_data_content == '0) || $isunknown(i_mem_data_content));

    always_comb begin
        word_sel = '0;
        case (phase_q)
            PhReg:     word_sel = i_register_content;
            PhLatch:   word_sel = DATA_W'(i_latches[32 * int'(idx_q) +: 32]);
            PhMemData: word_sel = i_mem_data_content;
            PhMemAddr: word_sel = DATA_W'(mem_addr_q);
            PhEnd:     word_sel = DATA_W'(WordEnd);
            default:   word_sel = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        ret_d          = ret_q;
        idx_d          = idx_q;
        load_cnt_d     = load_cnt_q;
        drain_cnt_d    = drain_cnt_q;
        drain_active_d = drain_active_q;
        bp_addr_d      = bp_addr_q;
        bp_mask_d      = bp_mask_q;
        prog_ready_d   = prog_ready_q;
        halt_d         = halt_q;
        rst_pulse_d    = 1'b0;
        wr_flag_d      = 1'b0;
        instr_d        = instr_q;
        inst_addr_d    = inst_addr_q;
        reg_addr_d     = reg_addr_q;
        mem_addr_d     = mem_addr_q;
        fifo_data_d    = fifo_data_q;
        fifo_we_d      = 1'b0;

        unique case (state_q)
            StIdle: if (i_data_ready) begin
                if (rx_word == CmdLoad) begin
                    state_d      = StLoad;
                    prog_ready_d = 1'b0;
                    inst_addr_d  = '0;
                    load_cnt_d   = '0;
                end else if (rx_word == CmdCont && prog_ready_q) begin
                    state_d        = StRun;
                    halt_d         = 1'b0;
                    drain_active_d = 1'b0;
                    drain_cnt_d    = '0;
                end else if (rx_word == CmdStep && prog_ready_q) begin
                    state_d = StStepWait;
                end else if (rx_word == CmdBp && prog_ready_q) begin
                    state_d = StBpAddr;
                end
            end
            StLoad: if (i_data_ready) begin
                wr_flag_d = 1'b1;
                instr_d   = rx_word;
                state_d   = StLoadWr;
            end
            StLoadWr: begin
                load_cnt_d = load_cnt_q + 1;
                if (instr_q == 32'hFFFF_FFFF || load_cnt_q == IMEM_WORDS - 1) begin
                    inst_addr_d  = '0;
                    prog_ready_d = 1'b1;
                    rst_pulse_d  = 1'b1;
                    state_d      = StIdle;
                end else begin
                    inst_addr_d = inst_addr_q + 32'd4;
                    state_d     = StLoad;
                end
            end
            StRun, StRunBp: begin
                if (i_pc != bp_addr_q) bp_mask_d = 1'b0;
                // A breakpoint hit takes priority over a drain completing in the same cycle.
                if (state_q == StRunBp && i_pc == bp_addr_q && !bp_mask_q) begin
                    halt_d  = 1'b1;
                    state_d = StDumpAddr;
                    phase_d = PhReg;
                    idx_d   = '0;
                    ret_d   = RetBp;
                end else if (drain_fire) begin
                    halt_d         = 1'b1;
                    state_d        = StDumpAddr;
                    phase_d        = PhReg;
                    idx_d          = '0;
                    ret_d          = RetIdle;
                    drain_active_d = 1'b0;
                end else if (drain_active_q) begin
                    drain_cnt_d = drain_cnt_q + 1;
                end else if (i_program_end) begin
                    drain_active_d = 1'b1;
                    drain_cnt_d    = '0;
                end
            end
            StStepWait, StBpWait: if (i_data_ready) begin
                if (rx_word == CmdNext) begin
                    halt_d    = 1'b0;
                    bp_mask_d = 1'b1;
                    state_d   = (state_q == StStepWait) ? StStepRun : StRunBp;
                end else if (rx_word == CmdClear) begin
                    rst_pulse_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StStepRun: begin
                halt_d  = 1'b1;
                state_d = StDumpAddr;
                phase_d = PhReg;
                idx_d   = '0;
                ret_d   = RetStep;
            end
            StBpAddr: if (i_data_ready) begin
                bp_addr_d      = rx_word;
                bp_mask_d      = 1'b0;
                halt_d         = 1'b0;
                drain_active_d = 1'b0;
                drain_cnt_d    = '0;
                state_d        = StRunBp;
            end
            StDumpAddr: begin
                if (phase_q == PhReg) reg_addr_d = idx_q[4:0];
                if (phase_q == PhMemData) mem_addr_d = 32'({idx_q, 2'b00});
                state_d = StDumpPush;
            end
            StDumpPush: if (skip_word || !i_fifo_full) begin
                fifo_we_d   = !skip_word;
                fifo_data_d = skip_word ? fifo_data_q : word_sel;
                state_d     = StDumpAddr;
                case (phase_q)
                    PhReg: if (idx_q == 16'(NREGS - 1)) begin
                        phase_d = PhLatch;
                        idx_d   = '0;
                    end else idx_d = idx_q + 1;
                    PhLatch: if (idx_q == 16'(LATCH_WORDS - 1)) begin
                        phase_d = PhMemData;
                        idx_d   = '0;
                    end else idx_d = idx_q + 1;
                    PhMemData, PhMemAddr: begin
                        if (phase_q == PhMemData && !skip_word) phase_d = PhMemAddr;
                        else if (idx_q == 16'(MemWords - 1)) phase_d = PhEnd;
                        else begin
                            phase_d = PhMemData;
                            idx_d   = idx_q + 1;
                        end
                    end
                    default: begin
                        case (ret_q)
                            RetStep: state_d = StStepWait;
                            RetBp:   state_d = StBpWait;
                            default: begin
                                state_d     = StIdle;
                                rst_pulse_d = 1'b1;
                            end
                        endcase
                    end
                endcase
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q        <= StIdle;
            phase_q        <= PhReg;
            ret_q          <= RetIdle;
            idx_q          <= '0;
            load_cnt_q     <= '0;
            drain_cnt_q    <= '0;
            drain_active_q <= 1'b0;
            bp_addr_q      <= '0;
            bp_mask_q      <= 1'b0;
            prog_ready_q   <= 1'b0;
            halt_q         <= 1'b1;
            rst_pulse_q    <= 1'b0;
            wr_flag_q      <= 1'b0;
            instr_q        <= '0;
            inst_addr_q    <= '0;
            reg_addr_q     <= '0;
            mem_addr_q     <= '0;
            fifo_data_q    <= '0;
            fifo_we_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            ret_q          <= ret_d;
            idx_q          <= idx_d;
            load_cnt_q     <= load_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            drain_active_q <= drain_active_d;
            bp_addr_q      <= bp_addr_d;
            bp_mask_q      <= bp_mask_d;
            prog_ready_q   <= prog_ready_d;
            halt_q         <= halt_d;
            rst_pulse_q    <= rst_pulse_d;
            wr_flag_q      <= wr_flag_d;
            instr_q        <= instr_d;
            inst_addr_q    <= inst_addr_d;
            reg_addr_q     <= reg_addr_d;
            mem_addr_q     <= mem_addr_d;
            fifo_data_q    <= fifo_data_d;
            fifo_we_q      <= fifo_we_d;
        end
    end

    assign o_halt                   = halt_q;
    assign o_reset                  = rst_pulse_q;
    assign o_write_instruction_flag = wr_flag_q;
    assign o_instruction_to_write   = instr_q;
    assign o_address_to_write_inst  = inst_addr_q;
    assign o_reg_addr_to_read       = reg_addr_q;
    assign o_addr_to_read_mem_data  = mem_addr_q;
    assign o_data_to_fifo           = fifo_data_q;
    assign o_write_en_fifo          = fifo_we_q;
endmodule

// File: tb/tb_debug_controller.sv
// Scoreboard bench for debug_controller: expected FIFO words and imem writes are queued by the
// stimulus and checked by an independent negedge monitor.
module tb_debug_controller;
    localparam logic [31:0] CmdLoad  = 32'h006c_6f6d;
    localparam logic [31:0] CmdCont  = 32'h0063_6f6d;
    localparam logic [31:0] CmdStep  = 32'h0073_746d;
    localparam logic [31:0] CmdBp    = 32'h0062_706d;
    localparam logic [31:0] CmdNext  = 32'h6e78_7374;
    localparam logic [31:0] CmdClear = 32'h636c_7374;
    localparam logic [31:0] WordEnd  = 32'h656e_6464;

    logic         clk = 1'b0;
    logic         i_reset, i_data_ready, i_fifo_full, i_program_end;
    logic [31:0]  i_data, i_pc, reg_content, mem_content;
    logic [351:0] latches;
    logic         o_halt, o_reset, o_write_instruction_flag, o_write_en_fifo;
    logic [31:0]  o_instruction_to_write, o_address_to_write_inst, o_addr_to_read_mem_data;
    logic [31:0]  o_data_to_fifo;
    logic [4:0]   o_reg_addr_to_read;
    logic [31:0]  mem [64];

    int          checks = 0, failures = 0;
    int          pushes = 0, rst_pulses = 0, halt_low = 0;
    bit          sb_en = 1'b1;
    logic [31:0] exp_q[$];
    logic [63:0] imem_q[$];

    always #5 clk = ~clk;

    // Environment models: register file, latch bus and data memory answer the DUT's read addresses.
    assign reg_content = 32'hA000_0000 | {27'd0, o_reg_addr_to_read};
    assign mem_content = mem[o_addr_to_read_mem_data[7:2]];
    always_comb begin
        latches = '0;
        for (int k = 0; k < 11; k++) latches[32*k +: 32] = 32'hC0DE_0000 + 32'(k);
    end

    debug_controller dut (
        .i_clk                    (clk),
        .i_reset                  (i_reset),
        .i_data_ready             (i_data_ready),
        .i_data                   (i_data),
        .i_fifo_full              (i_fifo_full),
        .i_program_end            (i_program_end),
        .i_pc                     (i_pc),
        .i_latches                (latches),
        .i_register_content       (reg_content),
        .i_mem_data_content       (mem_content),
        .o_halt                   (o_halt),
        .o_reset                  (o_reset),
        .o_write_instruction_flag (o_write_instruction_flag),
        .o_instruction_to_write   (o_instruction_to_write),
        .o_address_to_write_inst  (o_address_to_write_inst),
        .o_reg_addr_to_read       (o_reg_addr_to_read),
        .o_addr_to_read_mem_data  (o_addr_to_read_mem_data),
        .o_data_to_fifo           (o_data_to_fifo),
        .o_write_en_fifo          (o_write_en_fifo)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (o_reset) rst_pulses++;
        if (!o_halt) halt_low++;
        if (o_write_instruction_flag) begin
            if (imem_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL imem_unexpected got=%h", o_instruction_to_write);
            end else begin
                e = imem_q.pop_front();
                chk("imem_write", {o_address_to_write_inst, o_instruction_to_write}, e);
            end
        end
        if (sb_en && o_write_en_fifo) begin
            pushes++;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL fifo_unexpected got=%h", o_data_to_fifo);
            end else begin
                e = {32'd0, exp_q.pop_front()};
                chk("fifo_word", {32'd0, o_data_to_fifo}, e);
            end
        end
    end

    task automatic push_dump();
        for (int i = 0; i < 32; i++) exp_q.push_back(32'hA000_0000 + 32'(i));
        for (int k = 0; k < 11; k++) exp_q.push_back(32'hC0DE_0000 + 32'(k));
        for (int m = 0; m < 64; m++) begin
            if (mem[m] != 32'd0) begin
                exp_q.push_back(mem[m]);
                exp_q.push_back(32'(m * 4));
            end
        end
        exp_q.push_back(WordEnd);
    endtask

    task automatic send(input logic [31:0] w);
        @(negedge clk);
        i_data = w;
        i_data_ready = 1'b1;
        @(negedge clk);
        i_data_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_end();
        @(negedge clk);
        i_program_end = 1'b1;
        @(negedge clk);
        i_program_end = 1'b0;
    endtask

    initial begin
        int n, r, h, p0, cnt;
        logic [31:0] held;
        i_reset = 1'b1; i_data_ready = 1'b0; i_data = '0; i_fifo_full = 1'b0;
        i_program_end = 1'b0; i_pc = '0;
        for (int m = 0; m < 64; m++) mem[m] = '0;
        mem[1] = 32'h1111_1111; mem[5] = 32'h0000_0055; mem[63] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {60'd0, o_halt, o_reset, o_write_instruction_flag, o_write_en_fifo},
            64'h8);
        chk("reset_data", {32'd0, o_instruction_to_write | o_address_to_write_inst |
            o_addr_to_read_mem_data | o_data_to_fifo | {27'd0, o_reg_addr_to_read}}, 64'd0);
        i_reset = 1'b0;

        // Run before any load must be ignored.
        send(CmdCont);
        repeat (3) @(negedge clk);
        chk("guard_halt", {63'd0, o_halt}, 64'd1);

        r = rst_pulses;
        imem_q.push_back({32'd0,  32'h2008_0005});
        imem_q.push_back({32'd4,  32'h2009_0007});
        imem_q.push_back({32'd8,  32'h0109_5020});
        imem_q.push_back({32'd12, 32'hFFFF_FFFF});
        send(CmdLoad);
        send(32'h2008_0005); send(32'h2009_0007); send(32'h0109_5020); send(32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        chk("load_all_written", 64'(imem_q.size()), 64'd0);
        chk("load_reset_pulse", 64'(rst_pulses - r), 64'd1);

        // Continuous run with drain latency and mid-dump backpressure.
        send(CmdCont);
        chk("run_halt_low", {63'd0, o_halt}, 64'd0);
        r = rst_pulses; p0 = pushes;
        push_dump();
        @(negedge clk);
        i_program_end = 1'b1;
        for (n = 0; n < 10; n++) begin
            @(posedge clk);
            #1 i_program_end = 1'b0;
            if (o_halt) break;
        end
        chk("drain_latency", 64'(n), 64'd3);
        n = 0;
        while (pushes < p0 + 5 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #2 i_fifo_full = 1'b1;
        held = o_data_to_fifo;
        cnt = 0;
        repeat (5) begin
            @(posedge clk);
            #1 if (o_write_en_fifo) cnt++;
        end
        chk("bp_no_push", 64'(cnt), 64'd0);
        chk("bp_data_hold", {32'd0, o_data_to_fifo}, {32'd0, held});
        i_fifo_full = 1'b0;
        wait_empty("run_dump");
        chk("run_word_count", 64'(pushes - p0), 64'd50);
        chk("run_reset_pulse", 64'(rst_pulses - r), 64'd1);

        // Single step: two steps, second with one memory word cleared, then clear.
        r = rst_pulses;
        send(CmdStep);
        chk("step_halt_held", {63'd0, o_halt}, 64'd1);
        for (int s = 0; s < 2; s++) begin
            if (s == 1) mem[5] = '0;
            h = halt_low;
            push_dump();
            send(CmdNext);
            wait_empty("step_dump");
            chk("step_halt_low_cycles", 64'(halt_low - h), 64'd1);
        end
        chk("step_no_reset_yet", 64'(rst_pulses - r), 64'd0);
        send(CmdClear);
        repeat (2) @(negedge clk);
        chk("step_clear_reset", 64'(rst_pulses - r), 64'd1);

        // Breakpoint at 0x10, masked resume, then drain ends the run.
        i_pc = 32'h8;
        send(CmdBp);
        send(32'h0000_0010);
        repeat (3) @(negedge clk);
        chk("bpm_running", {63'd0, o_halt}, 64'd0);
        push_dump();
        @(negedge clk);
        i_pc = 32'h10;
        @(posedge clk);
        #1 chk("bpm_hit_halt", {63'd0, o_halt}, 64'd1);
        wait_empty("bpm_dump");
        chk("bpm_wait_halt", {63'd0, o_halt}, 64'd1);
        send(CmdNext);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (!o_halt) cnt++;
        end
        chk("bpm_masked", 64'(cnt), 64'd4);
        i_pc = 32'h14;
        r = rst_pulses;
        push_dump();
        pulse_end();
        wait_empty("bpm_drain_dump");
        chk("bpm_drain_reset", 64'(rst_pulses - r), 64'd1);

        // Reset in the middle of a dump.
        send(CmdCont);
        p0 = pushes;
        push_dump();
        pulse_end();
        n = 0;
        while (pushes < p0 + 10 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #2 sb_en = 1'b0;
        i_reset = 1'b1;
        @(posedge clk);
        #1 chk("abort_we", {63'd0, o_write_en_fifo}, 64'd0);
        chk("abort_halt", {63'd0, o_halt}, 64'd1);
        i_reset = 1'b0;
        exp_q.delete();
        cnt = 0;
        repeat (300) begin
            @(posedge clk);
            #1 if (o_write_en_fifo) cnt++;
        end
        chk("abort_no_push", 64'(cnt), 64'd0);
        sb_en = 1'b1;
        send(CmdCont);
        repeat (3) @(negedge clk);
        chk("abort_prog_cleared", {63'd0, o_halt}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
